// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit core front end: fetch FSM states,
// bubble opcode, boot vector location and the two-byte opcode group.
package cpu_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 8;

  localparam logic [7:0] RESET_VEC_ADDR = 8'h00;
  localparam logic [7:0] NOP_OPC        = 8'h00;
  // Upper nibble of LDM/LDD/STD, which carry an immediate byte
  localparam logic [3:0] TWO_BYTE_NIB   = 4'hC;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    IMM  = 2'd2
  } fetch_state_t;

  function automatic logic is_two_byte(input logic [7:0] opc);
    return (opc[7:4] == TWO_BYTE_NIB);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset > flush (bubble) > hold (en low) > load.
// A bubble request on the load path also produces a bubble.
module if_id_reg #(
  parameter int                  ADDR_W  = 8,
  parameter int                  INSTR_W = 8,
  parameter logic [INSTR_W-1:0]  NOP_OPC = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               en,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [INSTR_W-1:0] imm_in,
  input  logic [ADDR_W-1:0]  pc_next_in,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] imm,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               valid
);

  // Pipeline register update with bubble insertion
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr   <= NOP_OPC;
      imm     <= '0;
      pc_next <= '0;
      valid   <= 1'b0;
    end else if (!en) begin
      instr   <= instr;
      imm     <= imm;
      pc_next <= pc_next;
      valid   <= valid;
    end else if (bubble) begin
      instr   <= NOP_OPC;
      imm     <= '0;
      pc_next <= '0;
      valid   <= 1'b0;
    end else begin
      instr   <= instr_in;
      imm     <= imm_in;
      pc_next <= pc_next_in;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, boot-vector load, opcode+immediate assembly, IF/ID.
// Optional FETCH_PERF_CNT_EN adds saturating instruction/bubble counters.
module fetch_unit #(
  parameter int                 ADDR_W         = cpu_pkg::ADDR_W_DEF,
  parameter int                 INSTR_W        = cpu_pkg::INSTR_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_VEC_ADDR = cpu_pkg::RESET_VEC_ADDR,
  parameter logic [INSTR_W-1:0] NOP_OPC        = cpu_pkg::NOP_OPC
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_F,
  input  logic               stall_D,
  input  logic               flush_D,
  input  logic               branch_taken_E,
  input  logic [ADDR_W-1:0]  branch_target_E,
  input  logic               ret_load_W,
  input  logic [ADDR_W-1:0]  ret_target_W,
  output logic [INSTR_W-1:0] instr_D,
  output logic [INSTR_W-1:0] imm_D,
  output logic [ADDR_W-1:0]  pc_next_D,
  output logic               valid_D
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_instr_cnt,
  output logic [15:0]        perf_bubble_cnt
`endif
);

  import cpu_pkg::*;

  fetch_state_t       state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n, pc_inc;
  logic [INSTR_W-1:0] hold_op, hold_op_n;
  logic [INSTR_W-1:0] ld_instr, ld_imm;
  logic               redirect, bubble, flush_eff;

  assign pc_inc    = pc + ADDR_W'(1);
  assign imem_addr = (state == BOOT) ? RESET_VEC_ADDR : pc;
  // Redirects and boot must never leave a wrong-path instruction in decode
  assign flush_eff = flush_D | redirect;

  // Next PC / state / held opcode and the IF/ID load value
  always_comb begin
    pc_n      = pc;
    state_n   = state;
    hold_op_n = hold_op;
    redirect  = 1'b0;
    bubble    = 1'b1;
    ld_instr  = NOP_OPC;
    ld_imm    = '0;
    case (state)
      BOOT: begin
        pc_n     = ADDR_W'(imem_rdata);
        state_n  = RUN;
        redirect = 1'b1;
      end
      RUN, IMM: begin
        if (ret_load_W) begin
          pc_n     = ret_target_W;
          state_n  = RUN;
          redirect = 1'b1;
        end else if (branch_taken_E) begin
          pc_n      = branch_target_E;
          state_n   = RUN;
          hold_op_n = NOP_OPC;
          redirect  = 1'b1;
        end else if (!stall_F) begin
          bubble = 1'b1;
        end else if (state == IMM) begin
          pc_n     = pc_inc;
          state_n  = RUN;
          bubble   = 1'b0;
          ld_instr = hold_op;
          ld_imm   = imem_rdata;
        end else if (is_two_byte(8'(imem_rdata))) begin
          hold_op_n = imem_rdata;
          pc_n      = pc_inc;
          state_n   = IMM;
        end else begin
          pc_n     = pc_inc;
          bubble   = 1'b0;
          ld_instr = imem_rdata;
        end
      end
      default: begin
        state_n  = BOOT;
        redirect = 1'b1;
      end
    endcase
  end

  // PC, FSM state and held opcode
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      state   <= BOOT;
      hold_op <= NOP_OPC;
    end else begin
      pc      <= pc_n;
      state   <= state_n;
      hold_op <= hold_op_n;
    end
  end

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .NOP_OPC (NOP_OPC)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush_eff),
    .en         (stall_D),
    .bubble     (bubble),
    .instr_in   (ld_instr),
    .imm_in     (ld_imm),
    .pc_next_in (pc_inc),
    .instr      (instr_D),
    .imm        (imm_D),
    .pc_next    (pc_next_D),
    .valid      (valid_D)
  );

`ifdef FETCH_PERF_CNT_EN
  logic load_real, load_bubble;

  assign load_real   = !flush_eff && stall_D && !bubble;
  assign load_bubble = flush_eff || (stall_D && bubble) || !stall_F;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_instr_cnt  <= 16'h0000;
      perf_bubble_cnt <= 16'h0000;
    end else begin
      if (load_real && (perf_instr_cnt != 16'hFFFF)) begin
        perf_instr_cnt <= perf_instr_cnt + 16'h0001;
      end else begin
        perf_instr_cnt <= perf_instr_cnt;
      end
      if (load_bubble && (perf_bubble_cnt != 16'hFFFF)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 16'h0001;
      end else begin
        perf_bubble_cnt <= perf_bubble_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, two-byte assembly, stalls, branch,
// RET drain, PC wrap, redirect priority, flush-over-stall and mid-run reset.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       stall_F, stall_D, flush_D;
  logic       branch_taken_E, ret_load_W;
  logic [7:0] branch_target_E, ret_target_W;
  logic [7:0] instr_D, imm_D, pc_next_D;
  logic       valid_D;

  logic [7:0] mem [0:255];
  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall_F         (stall_F),
    .stall_D         (stall_D),
    .flush_D         (flush_D),
    .branch_taken_E  (branch_taken_E),
    .branch_target_E (branch_target_E),
    .ret_load_W      (ret_load_W),
    .ret_target_W    (ret_target_W),
    .instr_D         (instr_D),
    .imm_D           (imm_D),
    .pc_next_D       (pc_next_D),
    .valid_D         (valid_D)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10;  // boot vector
    mem[8'h10] = 8'h21;
    mem[8'h11] = 8'hC4; mem[8'h12] = 8'h5A;
    mem[8'h13] = 8'h31; mem[8'h14] = 8'h32;
    mem[8'h15] = 8'hC7; mem[8'h16] = 8'h66;
    mem[8'h17] = 8'hC8; mem[8'h18] = 8'h99;
    mem[8'h40] = 8'h23; mem[8'h41] = 8'h24;
    mem[8'h33] = 8'h25;
    mem[8'hFF] = 8'h26;
    mem[8'h20] = 8'h27; mem[8'h21] = 8'h28; mem[8'h22] = 8'hC1;

    rst = 1'b1; stall_F = 1'b1; stall_D = 1'b1; flush_D = 1'b0;
    branch_taken_E = 1'b0; branch_target_E = 8'h00;
    ret_load_W = 1'b0; ret_target_W = 8'h00;

    tick(); tick();
    chk("rst_instr", instr_D, 8'h00);
    chk("rst_imm", imm_D, 8'h00);
    chk("rst_pcnext", pc_next_D, 8'h00);
    chk("rst_valid", {7'd0, valid_D}, 8'h00);
    chk("rst_addr", imem_addr, 8'h00);
    rst = 1'b0;

    chk("boot_addr", imem_addr, 8'h00);
    tick();
    chk("boot_pc", imem_addr, 8'h10);
    chk("boot_bubble", {7'd0, valid_D}, 8'h00);
    tick();
    chk("one_instr", instr_D, 8'h21);
    chk("one_imm", imm_D, 8'h00);
    chk("one_pcnext", pc_next_D, 8'h11);
    chk("one_valid", {7'd0, valid_D}, 8'h01);
    tick();
    chk("two_bubble", {7'd0, valid_D}, 8'h00);
    chk("two_addr", imem_addr, 8'h12);
    tick();
    chk("two_instr", instr_D, 8'hC4);
    chk("two_imm", imm_D, 8'h5A);
    chk("two_pcnext", pc_next_D, 8'h13);
    chk("two_valid", {7'd0, valid_D}, 8'h01);

    // load-use stall in RUN
    stall_F = 1'b0; stall_D = 1'b0;
    tick();
    chk("stall_addr", imem_addr, 8'h13);
    chk("stall_hold", instr_D, 8'hC4);
    stall_F = 1'b1; stall_D = 1'b1;
    tick();
    chk("resume1", instr_D, 8'h31);
    chk("resume1_pc", pc_next_D, 8'h14);
    tick();
    chk("resume2", instr_D, 8'h32);
    chk("resume2_pc", pc_next_D, 8'h15);

    // stall inside IMM
    tick();
    chk("imm_enter", {7'd0, valid_D}, 8'h00);
    chk("imm_addr", imem_addr, 8'h16);
    stall_F = 1'b0; stall_D = 1'b0;
    tick();
    chk("imm_stall_addr", imem_addr, 8'h16);
    chk("imm_stall_valid", {7'd0, valid_D}, 8'h00);
    stall_F = 1'b1; stall_D = 1'b1;
    tick();
    chk("imm_hold_op", instr_D, 8'hC7);
    chk("imm_hold_imm", imm_D, 8'h66);
    chk("imm_hold_pc", pc_next_D, 8'h17);

    // branch during IMM
    tick();
    chk("br_imm_bubble", {7'd0, valid_D}, 8'h00);
    branch_taken_E = 1'b1; branch_target_E = 8'h40; flush_D = 1'b1;
    tick();
    chk("br_valid", {7'd0, valid_D}, 8'h00);
    chk("br_instr", instr_D, 8'h00);
    chk("br_addr", imem_addr, 8'h40);
    branch_taken_E = 1'b0; flush_D = 1'b0;
    tick();
    chk("br_tgt_instr", instr_D, 8'h23);
    chk("br_no_stale_imm", imm_D, 8'h00);
    chk("br_tgt_pc", pc_next_D, 8'h41);

    // RET drain
    stall_F = 1'b0;
    tick();
    chk("ret_drain_addr", imem_addr, 8'h41);
    chk("ret_drain_valid", {7'd0, valid_D}, 8'h00);
    tick(); tick();
    chk("ret_drain_addr3", imem_addr, 8'h41);
    ret_load_W = 1'b1; ret_target_W = 8'h33;
    tick();
    chk("ret_addr", imem_addr, 8'h33);
    chk("ret_valid", {7'd0, valid_D}, 8'h00);
    ret_load_W = 1'b0; stall_F = 1'b1;
    tick();
    chk("ret_instr", instr_D, 8'h25);
    chk("ret_pcnext", pc_next_D, 8'h34);

    // PC wrap with a one-byte opcode at FF
    branch_taken_E = 1'b1; branch_target_E = 8'hFF; flush_D = 1'b1;
    tick();
    chk("wrap_addr", imem_addr, 8'hFF);
    branch_taken_E = 1'b0; flush_D = 1'b0;
    tick();
    chk("wrap_instr", instr_D, 8'h26);
    chk("wrap_pcnext", pc_next_D, 8'h00);
    chk("wrap_addr0", imem_addr, 8'h00);

    // two-byte opcode at FF takes its immediate from 00
    mem[8'hFF] = 8'hCA;
    branch_taken_E = 1'b1; branch_target_E = 8'hFF; flush_D = 1'b1;
    tick();
    branch_taken_E = 1'b0; flush_D = 1'b0;
    tick();
    chk("wrap2_bubble", {7'd0, valid_D}, 8'h00);
    chk("wrap2_addr", imem_addr, 8'h00);
    tick();
    chk("wrap2_instr", instr_D, 8'hCA);
    chk("wrap2_imm", imm_D, 8'h10);
    chk("wrap2_pcnext", pc_next_D, 8'h01);

    // ret_load_W beats branch_taken_E
    ret_load_W = 1'b1; ret_target_W = 8'h20;
    branch_taken_E = 1'b1; branch_target_E = 8'h30;
    tick();
    chk("prio_addr", imem_addr, 8'h20);
    ret_load_W = 1'b0; branch_taken_E = 1'b0;
    tick();
    chk("prio_instr", instr_D, 8'h27);
    chk("prio_pcnext", pc_next_D, 8'h21);

    // flush_D wins over stall_D
    flush_D = 1'b1; stall_D = 1'b0;
    tick();
    chk("flush_over_stall", {7'd0, valid_D}, 8'h00);
    flush_D = 1'b0; stall_D = 1'b1;
    tick();
    chk("mid_imm", {7'd0, valid_D}, 8'h00);

    // reset in the middle of a two-byte fetch
    rst = 1'b1;
    tick();
    chk("rst2_addr", imem_addr, 8'h00);
    chk("rst2_valid", {7'd0, valid_D}, 8'h00);
    chk("rst2_instr", instr_D, 8'h00);
    rst = 1'b0;
    tick();
    chk("reboot_addr", imem_addr, 8'h10);
    tick();
    chk("reboot_instr", instr_D, 8'h21);
    chk("reboot_valid", {7'd0, valid_D}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
